// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Bit counter width: clog2(width), never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_ha.sv
// Full adder built from two half-adder cells plus an OR of their carries.
// Latency: combinational.
// Backpressure: none.
module fa_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/ha.sv
// Half adder cell: s = a ^ b, c = a & b.
// Latency: combinational.
// Backpressure: none.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency: done pulses in the cycle after edge T0+WIDTH; accept-to-accept is WIDTH+2 cycles.
// Backpressure: start is ignored while busy; no request is queued.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             s_bit
);

  localparam int                CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH:0]   sum_cat;

  fa_ha u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (cnt == CNT_LAST);
  // New sum bit enters at the MSB end; slicing the concatenation also covers WIDTH=1.
  assign sum_cat  = {fa_s, sum_sr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: IDLE waits for start, SHIFT runs WIDTH cycles, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)    state_nx = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nx = ST_DONE;
      ST_DONE:                state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Output decode: busy outside IDLE, done in DONE, serial bit only while shifting.
  always_comb begin
    busy  = (state != ST_IDLE);
    done  = (state == ST_DONE);
    s_bit = (state == ST_SHIFT) ? fa_s : 1'b0;
  end

  // Datapath: operand capture, bit-serial add, and result registers updated on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sr <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_cat[WIDTH:1];
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_cat[WIDTH:1];
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an arithmetic reference (a+b+cin).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         s_bit;

  int checks;
  int failures;

  // Last completed result; sum/cout must hold this until the next operation completes.
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .s_bit (s_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from start to return to IDLE, checked cycle by cycle.
  // glitch_at >= 0 drives start and new operands during that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tc,
                        input int glitch_at, input string tag);
    logic [W:0] exp;
    exp = {1'b0, ta} + {1'b0, tb_in} + {{W{1'b0}}, tc};
    @(negedge clk);
    a = ta; b = tb_in; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < W; j++) begin
      chk({tag, " busy_shift"}, {31'b0, busy}, 32'd1);
      chk({tag, " done_early"}, {31'b0, done}, 32'd0);
      chk({tag, " s_bit"},      {31'b0, s_bit}, {31'b0, exp[j]});
      chk({tag, " sum_hold"},   {24'b0, sum}, {24'b0, prev_sum});
      chk({tag, " cout_hold"},  {31'b0, cout}, {31'b0, prev_cout});
      if (j == glitch_at) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, " done"},      {31'b0, done}, 32'd1);
    chk({tag, " busy_done"}, {31'b0, busy}, 32'd1);
    chk({tag, " s_bit_done"},{31'b0, s_bit}, 32'd0);
    chk({tag, " sum"},       {24'b0, sum}, {24'b0, exp[W-1:0]});
    chk({tag, " cout"},      {31'b0, cout}, {31'b0, exp[W]});
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
    @(negedge clk);
    chk({tag, " done_once"}, {31'b0, done}, 32'd0);
    chk({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, " sum_idle"},  {24'b0, sum}, {24'b0, prev_sum});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state.
    #1;
    chk("rst busy",  {31'b0, busy}, 32'd0);
    chk("rst done",  {31'b0, done}, 32'd0);
    chk("rst cout",  {31'b0, cout}, 32'd0);
    chk("rst s_bit", {31'b0, s_bit}, 32'd0);
    chk("rst sum",   {24'b0, sum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", {31'b0, busy}, 32'd0);

    // Directed operations.
    run_op(8'h0F, 8'h01, 1'b0, -1, "t2");
    run_op(8'hFF, 8'h01, 1'b0, -1, "t3");
    run_op(8'hFF, 8'hFF, 1'b1, -1, "t4a");
    run_op(8'h00, 8'h00, 1'b0, -1, "t4b");
    run_op(8'h5A, 8'h3C, 1'b0,  3, "t5");

    // Reset in the middle of an operation: immediate abort, no done.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6 busy",  {31'b0, busy}, 32'd0);
    chk("t6 done",  {31'b0, done}, 32'd0);
    chk("t6 sum",   {24'b0, sum}, 32'd0);
    chk("t6 cout",  {31'b0, cout}, 32'd0);
    chk("t6 s_bit", {31'b0, s_bit}, 32'd0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6 no_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    run_op(8'h80, 8'h80, 1'b0, -1, "t6b");

    // Randomized operations, some with ignored start pulses mid-shift.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           g;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      g  = (n % 3 == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_op(ra, rb, rc, g, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
